mem_stage_access_ctrl: RTL and testbench
========================================

# mem_stage_access_ctrl

Memory-stage consumer of the EX/MEM pipeline register. It takes the registered EX/MEM fields, runs loads and stores against a handshaked data memory, and stalls the upstream pipeline while an access is outstanding. It selects the write-back value and registers the MEM/WB fields for the write-back stage. It also detects memory timeouts and reports them as a sticky error.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum cycles in REQ without dmem_ready before the access is aborted; legal range 1–255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- RegWrite_n  in  1  EX/MEM register-write enable.
- link_pc_n  in  16  link PC.
- mem_read_n  in  1  load request.
- mem_write_n  in  1  store request.
- write_back_n  in  2  write-back select: 00 ALU, 01 memory, 10 shift, 11 link PC.
- ALU_output_n  in  16  ALU result; also the memory address.
- shift_output_n  in  16  shifter result.
- write_address_n  in  4  destination register.
- data_memory_write_n  in  16  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 for a store, 0 for a load.
- dmem_addr  out  16  memory address.
- dmem_wdata  out  16  store data.
- dmem_ready  in  1  memory completion for the current request.
- dmem_rdata  in  16  load data, valid when dmem_ready=1.
- stall  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- RegWrite_wb  out  1  MEM/WB register-write enable.
- write_address_wb  out  4  MEM/WB destination register.
- write_data_wb  out  16  MEM/WB write-back data.
- mem_err  out  1  sticky timeout flag.

## Operation
States:
- IDLE: no memory access outstanding.
- REQ: memory request outstanding.

Access classification:
- An access is present when mem_read_n | mem_write_n.
- If both are set, the access is a store; the read is ignored.

IDLE behaviour:
- No access present: the inputs pass to MEM/WB at the next edge; write_data_wb is selected by write_back_n; stall=0.
- Access present:
  - stall=1 combinationally.
  - At the edge, latch all EX/MEM fields into holding registers and go to REQ.
  - MEM/WB receives a bubble (RegWrite_wb=0).

REQ behaviour:
- dmem_req=1; dmem_we, dmem_addr and dmem_wdata are driven from the holding registers and stay stable until completion.
- stall = ~dmem_ready.
- dmem_ready=1:
  - MEM/WB loads the held fields at the edge; dmem_rdata is used when the held select is 01.
  - Go to IDLE; the timeout counter clears.
- dmem_ready=0:
  - Timeout counter increments; MEM/WB receives a bubble.
  - When the counter reaches MEM_TIMEOUT: at that edge drop the request and set mem_err.
  - Write back the held fields with RegWrite_wb forced to 0, go to IDLE, and deassert stall in that final cycle.
- mem_err clears only on reset.

Write-back data:
- Zero-extension is never applied; all data paths are 16 bits.
- A store with RegWrite_n=1 writes back the selected non-memory value.

## Timing
- Reset values: state IDLE, counter 0, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, stall 0, RegWrite_wb 0, write_address_wb 0, write_data_wb 0, mem_err 0.
- Non-memory instruction: MEM/WB outputs are valid one edge after the instruction is presented; zero stall.
- Memory access with ready in the first REQ cycle: one stall cycle; MEM/WB is valid two edges after presentation.
- Each additional wait cycle adds one stall cycle.
- Timeout: stall is asserted for MEM_TIMEOUT+1 cycles in total; mem_err rises at the same edge that returns the FSM to IDLE.
- dmem_ready sampled while in IDLE is ignored.
- Reset during REQ: dmem_req and stall drop asynchronously; the held access is discarded and no write-back occurs.
- Back-to-back memory instructions: the instruction following a completed access is evaluated in IDLE on the next cycle; there is no overlap of requests.

## Structure
- Package mem_stage_pkg:
  - state enum {IDLE, REQ};
  - write-back select constants WB_ALU=2'b00, WB_MEM=2'b01, WB_SHIFT=2'b10, WB_LINK=2'b11;
  - 16-bit data width constant.
- Sub-module mem_wb_result_mux: combinational 4:1 select of write_data from ALU, memory, shift and link PC. It is instantiated once and fed from the live inputs in IDLE and from the holding registers in REQ.

## Test plan
- Reset, then ALU op with ALU_output=16'h1234, write_back=00, RegWrite=1, write_address=3 → next edge: RegWrite_wb=1, write_address_wb=3, write_data_wb=16'h1234; stall never asserted.
- Load with address 16'h0040, memory ready after 2 wait cycles with rdata=16'hBEEF → dmem_req high 3 cycles with dmem_we=0 and dmem_addr=16'h0040; stall high 3 cycles; write_data_wb=16'hBEEF, RegWrite_wb=1.
- Store with both mem_read and mem_write set, data 16'h5A5A at 16'h0010, ready immediately → dmem_we=1, dmem_wdata=16'h5A5A; stall for one cycle; RegWrite_wb=0.
- Load with dmem_ready held low, MEM_TIMEOUT=4 → dmem_req drops after 5 REQ cycles; mem_err=1 and stays 1 across later traffic; RegWrite_wb=0 for that load.
- Reset pulled low during the second REQ cycle → dmem_req=0 and stall=0 immediately; after release, no write-back for the aborted load and all outputs are at their reset values.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_SHIFT = 2'b10;
  localparam logic [1:0] WB_LINK  = 2'b11;

  // Snapshot of the EX/MEM fields needed to finish an access and write back.
  typedef struct packed {
    logic              reg_write;
    logic [DATA_W-1:0] link_pc;
    logic              we;
    logic [1:0]        wb_sel;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] shift;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wdata;
  } exmem_t;

endpackage

// File: rtl/mem_wb_result_mux.sv
// Write-back data select between ALU, memory, shifter and link PC.
// Latency: combinational.
// Backpressure: none; pure datapath.
module mem_wb_result_mux
  import mem_stage_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] mem,
  input  logic [DATA_W-1:0] shift,
  input  logic [DATA_W-1:0] link,
  output logic [DATA_W-1:0] result
);

  // 4:1 select on the write-back code.
  always_comb begin
    result = alu;
    unique case (sel)
      WB_ALU:   result = alu;
      WB_MEM:   result = mem;
      WB_SHIFT: result = shift;
      WB_LINK:  result = link;
      default:  result = alu;
    endcase
  end

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// MEM stage: runs loads/stores on a ready-handshaked dmem and registers MEM/WB.
// Latency: 1 edge for non-memory ops; 2 edges plus wait cycles for accesses.
// Backpressure: stall holds upstream while an access is outstanding; timeout aborts it.
module mem_stage_access_ctrl
  import mem_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_n,
  input  logic [DATA_W-1:0] link_pc_n,
  input  logic              mem_read_n,
  input  logic              mem_write_n,
  input  logic [1:0]        write_back_n,
  input  logic [DATA_W-1:0] ALU_output_n,
  input  logic [DATA_W-1:0] shift_output_n,
  input  logic [3:0]        write_address_n,
  input  logic [DATA_W-1:0] data_memory_write_n,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              RegWrite_wb,
  output logic [3:0]        write_address_wb,
  output logic [DATA_W-1:0] write_data_wb,
  output logic              mem_err
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t            state;
  logic [7:0]        wait_cnt;
  exmem_t            hold;
  exmem_t            live;
  exmem_t            src;
  logic              access;
  logic              tmo_hit;
  logic [DATA_W-1:0] wb_data;

  // A store wins when both read and write are flagged; only we is kept.
  assign access  = mem_read_n | mem_write_n;
  assign tmo_hit = (wait_cnt == TMO);

  // Gather the live EX/MEM fields into one word.
  always_comb begin
    live           = '0;
    live.reg_write = RegWrite_n;
    live.link_pc   = link_pc_n;
    live.we        = mem_write_n;
    live.wb_sel    = write_back_n;
    live.alu       = ALU_output_n;
    live.shift     = shift_output_n;
    live.wr_addr   = write_address_n;
    live.wdata     = data_memory_write_n;
  end

  // Single result mux: live fields while idle, held fields while a request is out.
  assign src = (state == REQ) ? hold : live;

  mem_wb_result_mux u_wb_mux (
    .sel    (src.wb_sel),
    .alu    (src.alu),
    .mem    (dmem_rdata),
    .shift  (src.shift),
    .link   (src.link_pc),
    .result (wb_data)
  );

  // Request bus comes straight from the snapshot so it cannot move mid-access.
  assign dmem_we    = hold.we;
  assign dmem_addr  = hold.alu;
  assign dmem_wdata = hold.wdata;

  // Stall while an access is being issued or waited on; released in the
  // completion or abort cycle, and forced low while reset is asserted.
  assign stall = reset & ((state == IDLE) ? access : (~dmem_ready & ~tmo_hit));

  // Access FSM with registered request, MEM/WB fields and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      hold             <= '0;
      dmem_req         <= 1'b0;
      RegWrite_wb      <= 1'b0;
      write_address_wb <= '0;
      write_data_wb    <= '0;
      mem_err          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            hold        <= live;
            dmem_req    <= 1'b1;
            RegWrite_wb <= 1'b0;
            state       <= REQ;
          end else begin
            RegWrite_wb      <= RegWrite_n;
            write_address_wb <= write_address_n;
            write_data_wb    <= wb_data;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            RegWrite_wb      <= hold.reg_write;
            write_address_wb <= hold.wr_addr;
            write_data_wb    <= wb_data;
            dmem_req         <= 1'b0;
            wait_cnt         <= '0;
            state            <= IDLE;
          end else if (tmo_hit) begin
            RegWrite_wb      <= 1'b0;
            write_address_wb <= hold.wr_addr;
            write_data_wb    <= wb_data;
            dmem_req         <= 1'b0;
            mem_err          <= 1'b1;
            wait_cnt         <= '0;
            state            <= IDLE;
          end else begin
            RegWrite_wb <= 1'b0;
            wait_cnt    <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
module tb_mem_stage_access_ctrl;

  localparam int TMO = 4;
  localparam int NEVER = 1000;

  typedef struct {
    logic        rw;
    logic [15:0] link;
    logic        rd;
    logic        wr;
    logic [1:0]  sel;
    logic [15:0] alu;
    logic [15:0] sh;
    logic [3:0]  wa;
    logic [15:0] wd;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite_n = 1'b0;
  logic [15:0] link_pc_n = '0;
  logic        mem_read_n = 1'b0;
  logic        mem_write_n = 1'b0;
  logic [1:0]  write_back_n = '0;
  logic [15:0] ALU_output_n = '0;
  logic [15:0] shift_output_n = '0;
  logic [3:0]  write_address_n = '0;
  logic [15:0] data_memory_write_n = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        stall;
  logic        RegWrite_wb;
  logic [3:0]  write_address_wb;
  logic [15:0] write_data_wb;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_stage_access_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .RegWrite_n(RegWrite_n), .link_pc_n(link_pc_n),
    .mem_read_n(mem_read_n), .mem_write_n(mem_write_n), .write_back_n(write_back_n),
    .ALU_output_n(ALU_output_n), .shift_output_n(shift_output_n),
    .write_address_n(write_address_n), .data_memory_write_n(data_memory_write_n),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall),
    .RegWrite_wb(RegWrite_wb), .write_address_wb(write_address_wb),
    .write_data_wb(write_data_wb), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog");
  end

  // Reference: what one instruction must produce, given the memory answers
  // after w wait cycles (w > TMO means it never answers in time).
  function automatic void model(input instr_t in, input int w, input logic [15:0] rdat,
                                output int e_stall, output int e_req, output logic e_rw,
                                output logic [15:0] e_data, output logic e_err);
    logic [15:0] v;
    if (in.sel == 2'b00) v = in.alu;
    else if (in.sel == 2'b01) v = rdat;
    else if (in.sel == 2'b10) v = in.sh;
    else v = in.link;
    e_data = v;
    if (!(in.rd || in.wr)) begin
      e_stall = 0; e_req = 0; e_rw = in.rw; e_err = 1'b0;
    end else if (w <= TMO) begin
      e_stall = w + 1; e_req = w + 1; e_rw = in.rw; e_err = 1'b0;
    end else begin
      e_stall = TMO + 1; e_req = TMO + 1; e_rw = 1'b0; e_err = 1'b1;
    end
  endfunction

  // Presents one instruction, plays the memory side, and measures what happened
  // until the first edge at which stall was low (the instruction retired).
  task automatic do_instr(input instr_t in, input int w, input logic [15:0] rdat,
                          output int n_stall, output int n_req, output int n_bub_bad,
                          output logic b_we, output logic [15:0] b_addr, output logic [15:0] b_wdata,
                          output logic b_changed, output logic hung);
    bit done;
    int ridx;
    done = 0; ridx = 0; n_stall = 0; n_req = 0; n_bub_bad = 0;
    b_we = 1'b0; b_addr = '0; b_wdata = '0; b_changed = 1'b0; hung = 1'b0;
    RegWrite_n = in.rw; link_pc_n = in.link; mem_read_n = in.rd; mem_write_n = in.wr;
    write_back_n = in.sel; ALU_output_n = in.alu; shift_output_n = in.sh;
    write_address_n = in.wa; data_memory_write_n = in.wd;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (dmem_req === 1'b1) begin
        dmem_ready = (ridx == w);
        dmem_rdata = (ridx == w) ? rdat : 16'($urandom);
      end else begin
        dmem_ready = 1'($urandom);
        dmem_rdata = 16'($urandom);
      end
      #1;
      if (dmem_req === 1'b1) begin
        if (n_req == 0) begin
          b_we = dmem_we; b_addr = dmem_addr; b_wdata = dmem_wdata;
        end else if (dmem_we !== b_we || dmem_addr !== b_addr || dmem_wdata !== b_wdata) begin
          b_changed = 1'b1;
        end
        n_req++;
        ridx++;
      end
      if (stall === 1'b1) n_stall++;
      else done = 1;
      @(posedge clk); #1;
      if (!done && RegWrite_wb !== 1'b0) n_bub_bad++;
    end
    if (!done) hung = 1'b1;
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req: got %b want 0", dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    checks++; if ({dmem_we, dmem_addr, dmem_wdata} !== 33'h0) begin errors++; $display("FAIL rst_bus: got %b/%h/%h want 0/0000/0000", dmem_we, dmem_addr, dmem_wdata); end
    checks++; if ({RegWrite_wb, write_address_wb, write_data_wb} !== 21'h0) begin errors++; $display("FAIL rst_wb: got %b/%h/%h want 0/0/0000", RegWrite_wb, write_address_wb, write_data_wb); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_mem_err: got %b want 0", mem_err); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    instr_t in; int ns, nr, nb; logic bw, bc, hg; logic [15:0] ba, bd;
    in = '{rw:1'b1, link:16'h0, rd:1'b0, wr:1'b0, sel:2'b00, alu:16'h1234, sh:16'h9999, wa:4'd3, wd:16'h0};
    do_instr(in, 0, 16'h0, ns, nr, nb, bw, ba, bd, bc, hg);
    checks++; if (ns !== 0) begin errors++; $display("FAIL alu_stall: got %0d cycles want 0", ns); end
    checks++; if (nr !== 0) begin errors++; $display("FAIL alu_req: got %0d cycles want 0", nr); end
    checks++; if ({RegWrite_wb, write_address_wb, write_data_wb} !== {1'b1, 4'd3, 16'h1234}) begin errors++; $display("FAIL alu_wb: got %b/%h/%h want 1/3/1234", RegWrite_wb, write_address_wb, write_data_wb); end
  endtask

  task automatic test_load_wait();
    instr_t in; int ns, nr, nb; logic bw, bc, hg; logic [15:0] ba, bd;
    in = '{rw:1'b1, link:16'h0, rd:1'b1, wr:1'b0, sel:2'b01, alu:16'h0040, sh:16'h0, wa:4'd5, wd:16'h0};
    do_instr(in, 2, 16'hBEEF, ns, nr, nb, bw, ba, bd, bc, hg);
    checks++; if (nr !== 3) begin errors++; $display("FAIL load_req_cycles: got %0d want 3", nr); end
    checks++; if (ns !== 3) begin errors++; $display("FAIL load_stall_cycles: got %0d want 3", ns); end
    checks++; if ({bw, ba, bc} !== {1'b0, 16'h0040, 1'b0}) begin errors++; $display("FAIL load_bus: got we=%b addr=%h changed=%b want 0/0040/0", bw, ba, bc); end
    checks++; if ({RegWrite_wb, write_address_wb, write_data_wb} !== {1'b1, 4'd5, 16'hBEEF}) begin errors++; $display("FAIL load_wb: got %b/%h/%h want 1/5/beef", RegWrite_wb, write_address_wb, write_data_wb); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL load_bubble: got %0d non-bubbles want 0", nb); end
  endtask

  task automatic test_store_both();
    instr_t in; int ns, nr, nb; logic bw, bc, hg; logic [15:0] ba, bd;
    in = '{rw:1'b0, link:16'h0, rd:1'b1, wr:1'b1, sel:2'b00, alu:16'h0010, sh:16'h0, wa:4'd2, wd:16'h5A5A};
    do_instr(in, 0, 16'h0, ns, nr, nb, bw, ba, bd, bc, hg);
    checks++; if ({bw, ba, bd} !== {1'b1, 16'h0010, 16'h5A5A}) begin errors++; $display("FAIL store_bus: got we=%b addr=%h wdata=%h want 1/0010/5a5a", bw, ba, bd); end
    checks++; if (ns !== 1) begin errors++; $display("FAIL store_stall: got %0d want 1", ns); end
    checks++; if (RegWrite_wb !== 1'b0) begin errors++; $display("FAIL store_regwrite: got %b want 0", RegWrite_wb); end
  endtask

  task automatic test_timeout();
    instr_t in; int ns, nr, nb; logic bw, bc, hg; logic [15:0] ba, bd;
    in = '{rw:1'b1, link:16'h0, rd:1'b1, wr:1'b0, sel:2'b01, alu:16'h0077, sh:16'h0, wa:4'd7, wd:16'h0};
    do_instr(in, NEVER, 16'h0, ns, nr, nb, bw, ba, bd, bc, hg);
    checks++; if (nr !== TMO + 1) begin errors++; $display("FAIL tmo_req_cycles: got %0d want %0d", nr, TMO + 1); end
    checks++; if (ns !== TMO + 1) begin errors++; $display("FAIL tmo_stall_cycles: got %0d want %0d", ns, TMO + 1); end
    checks++; if (hg !== 1'b0) begin errors++; $display("FAIL tmo_hung: got %b want 0", hg); end
    checks++; if ({mem_err, RegWrite_wb, dmem_req} !== 3'b100) begin errors++; $display("FAIL tmo_state: got err=%b rw=%b req=%b want 1/0/0", mem_err, RegWrite_wb, dmem_req); end
    checks++; if (write_address_wb !== 4'd7) begin errors++; $display("FAIL tmo_addr: got %h want 7", write_address_wb); end
  endtask

  task automatic test_random();
    instr_t in; int ns, nr, nb, w, kind, es, er, st; logic bw, bc, hg, erw, eerr; logic [15:0] ba, bd, ed, rdat;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      in.rw = 1'($urandom); in.link = 16'($urandom); in.alu = 16'($urandom);
      in.sh = 16'($urandom); in.wa = 4'($urandom); in.wd = 16'($urandom);
      in.wr = (kind == 2);
      in.rd = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
      st = $urandom_range(0, 2);
      in.sel = (kind == 1) ? 2'($urandom) : ((st == 0) ? 2'b00 : 2'(st + 1));
      w = $urandom_range(0, TMO + 2);
      rdat = 16'($urandom);
      model(in, w, rdat, es, er, erw, ed, eerr);
      do_instr(in, w, rdat, ns, nr, nb, bw, ba, bd, bc, hg);
      checks++; if (ns !== es || nr !== er || hg !== 1'b0) begin errors++; $display("FAIL rnd%0d_cycles: got stall=%0d req=%0d hung=%b want %0d/%0d/0", i, ns, nr, hg, es, er); end
      checks++; if (RegWrite_wb !== erw || write_address_wb !== in.wa) begin errors++; $display("FAIL rnd%0d_wb_ctl: got %b/%h want %b/%h", i, RegWrite_wb, write_address_wb, erw, in.wa); end
      if (!(eerr && in.sel == 2'b01)) begin
        checks++; if (write_data_wb !== ed) begin errors++; $display("FAIL rnd%0d_wb_data: got %h want %h", i, write_data_wb, ed); end
      end
      if (kind != 0) begin
        checks++; if (bw !== in.wr || ba !== in.alu || bc !== 1'b0 || (in.wr && bd !== in.wd)) begin errors++; $display("FAIL rnd%0d_bus: got we=%b addr=%h wd=%h chg=%b want %b/%h/%h/0", i, bw, ba, bd, bc, in.wr, in.alu, in.wd); end
      end
      checks++; if (mem_err !== 1'b1 || nb !== 0) begin errors++; $display("FAIL rnd%0d_sticky: got err=%b nonbubbles=%0d want 1/0", i, mem_err, nb); end
    end
  endtask

  task automatic test_back_to_back();
    instr_t a, b; int ns, nr, nb; logic bw, bc, hg; logic [15:0] ba, bd;
    a = '{rw:1'b1, link:16'h0, rd:1'b1, wr:1'b0, sel:2'b01, alu:16'h0100, sh:16'h0, wa:4'd1, wd:16'h0};
    b = '{rw:1'b1, link:16'h0, rd:1'b1, wr:1'b0, sel:2'b01, alu:16'h0200, sh:16'h0, wa:4'd2, wd:16'h0};
    do_instr(a, 0, 16'hA001, ns, nr, nb, bw, ba, bd, bc, hg);
    checks++; if ({RegWrite_wb, write_address_wb, write_data_wb} !== {1'b1, 4'd1, 16'hA001}) begin errors++; $display("FAIL b2b_first: got %b/%h/%h want 1/1/a001", RegWrite_wb, write_address_wb, write_data_wb); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL b2b_gap: got req=%b want 0 in the cycle after completion", dmem_req); end
    do_instr(b, 1, 16'hB002, ns, nr, nb, bw, ba, bd, bc, hg);
    checks++; if ({nr, ns, ba} !== {32'd2, 32'd2, 16'h0200}) begin errors++; $display("FAIL b2b_second_bus: got req=%0d stall=%0d addr=%h want 2/2/0200", nr, ns, ba); end
    checks++; if ({RegWrite_wb, write_address_wb, write_data_wb} !== {1'b1, 4'd2, 16'hB002}) begin errors++; $display("FAIL b2b_second: got %b/%h/%h want 1/2/b002", RegWrite_wb, write_address_wb, write_data_wb); end
  endtask

  task automatic test_reset_midreq();
    RegWrite_n = 1'b1; mem_read_n = 1'b1; mem_write_n = 1'b0; write_back_n = 2'b01;
    ALU_output_n = 16'h0ABC; write_address_n = 4'd9; dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({dmem_req, stall} !== 2'b11) begin errors++; $display("FAIL rstreq_pre: got req=%b stall=%b want 1/1", dmem_req, stall); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({dmem_req, stall} !== 2'b00) begin errors++; $display("FAIL rstreq_async: got req=%b stall=%b want 0/0", dmem_req, stall); end
    RegWrite_n = 1'b0; mem_read_n = 1'b0; write_back_n = 2'b00; ALU_output_n = '0; write_address_n = '0;
    @(negedge clk); reset = 1'b1;
    #1;
    checks++; if ({dmem_req, stall, dmem_we, dmem_addr, dmem_wdata} !== 35'h0) begin errors++; $display("FAIL rstreq_bus: got %b/%b/%b/%h/%h want all 0", dmem_req, stall, dmem_we, dmem_addr, dmem_wdata); end
    checks++; if ({RegWrite_wb, write_address_wb, write_data_wb, mem_err} !== 22'h0) begin errors++; $display("FAIL rstreq_wb: got %b/%h/%h err=%b want all 0", RegWrite_wb, write_address_wb, write_data_wb, mem_err); end
    @(posedge clk); #1;
    checks++; if ({RegWrite_wb, dmem_req} !== 2'b00) begin errors++; $display("FAIL rstreq_after: got rw=%b req=%b want 0/0", RegWrite_wb, dmem_req); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store_both();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_midreq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
